// File: rtl/btb_array.sv
// Four-way set-associative branch target buffer. Fetch lookups are registered;
// resolved-taken updates go through a two-state write FSM with tree pseudo-LRU replacement.
//
// state | meaning
// IDLE  | accepting an update (update_ready=1)
// WRITE | captured update is written into its set at the end of this cycle
module btb_array #(
  parameter int b_sets = 3,
  parameter int way    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        lookup_hit,
  output logic [1:0]  lookup_way,
  output logic [31:0] lookup_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  output logic        update_ready
);
  localparam int n_sets = 1 << b_sets;
  localparam int tag_w  = 32 - b_sets - 2;

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;

  logic             valid_q [n_sets][way];
  logic [tag_w-1:0] tag_q   [n_sets][way];
  logic [31:0]      tgt_q   [n_sets][way];
  logic [2:0]       plru_q  [n_sets];
  logic [2:0]       plru_d  [n_sets];

  logic [31:2] up_pc_q;
  logic [31:0] up_tgt_q;

  logic [b_sets-1:0] l_idx, w_idx;
  logic [tag_w-1:0]  l_tag, w_tag;
  logic              unused_pc_lsbs;

  assign l_idx = lookup_pc[b_sets+1:2];
  assign l_tag = lookup_pc[31:b_sets+2];
  assign w_idx = up_pc_q[b_sets+1:2];
  assign w_tag = up_pc_q[31:b_sets+2];
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  function automatic logic [2:0] touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] r;
    r    = p;
    r[0] = w[1];
    if (w[1]) r[2] = w[0];
    else      r[1] = w[0];
    return r;
  endfunction

  logic        l_hit;
  logic [1:0]  l_way;
  logic [31:0] l_tgt;

  always_comb begin
    l_hit = 1'b0;
    l_way = '0;
    l_tgt = '0;
    for (int w = 0; w < way; w++) begin
      if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
        l_hit = 1'b1;
        l_way = 2'(w);
        l_tgt = tgt_q[l_idx][w];
      end
    end
  end

  logic       w_match, w_free;
  logic [1:0] w_match_way, w_free_way, w_victim, w_way;

  // Descending scan so the lowest-numbered invalid way is the one kept.
  always_comb begin
    w_match     = 1'b0;
    w_match_way = '0;
    w_free      = 1'b0;
    w_free_way  = '0;
    w_victim    = '0;
    for (int w = way - 1; w >= 0; w--) begin
      if (!valid_q[w_idx][w]) begin
        w_free     = 1'b1;
        w_free_way = 2'(w);
      end
      if (valid_q[w_idx][w] && tag_q[w_idx][w] == w_tag) begin
        w_match     = 1'b1;
        w_match_way = 2'(w);
      end
    end
    if (plru_q[w_idx][0]) w_victim = plru_q[w_idx][1] ? 2'd0 : 2'd1;
    else                  w_victim = plru_q[w_idx][2] ? 2'd2 : 2'd3;
    w_way = w_match ? w_match_way : (w_free ? w_free_way : w_victim);
  end

  // Lookup touch first, write touch second, so write bits win within a set.
  always_comb begin
    for (int s = 0; s < n_sets; s++) begin
      plru_d[s] = plru_q[s];
      if (lookup_valid && l_hit && l_idx == b_sets'(s))
        plru_d[s] = touch(plru_d[s], l_way);
      if (state == WRITE && w_idx == b_sets'(s))
        plru_d[s] = touch(plru_d[s], w_way);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < n_sets; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < way; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (flush) begin
      for (int s = 0; s < n_sets; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < way; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < n_sets; s++) plru_q[s] <= plru_d[s];
      if (state == WRITE) valid_q[w_idx][w_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == WRITE && !flush) begin
      tag_q[w_idx][w_way] <= w_tag;
      tgt_q[w_idx][w_way] <= up_tgt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      update_ready  <= 1'b1;
      up_pc_q       <= '0;
      up_tgt_q      <= '0;
      lookup_hit    <= 1'b0;
      lookup_way    <= '0;
      lookup_target <= '0;
    end else begin
      if (flush || !lookup_valid) begin
        lookup_hit    <= 1'b0;
        lookup_way    <= '0;
        lookup_target <= '0;
      end else begin
        lookup_hit    <= l_hit;
        lookup_way    <= l_way;
        lookup_target <= l_tgt;
      end
      if (flush) begin
        state        <= IDLE;
        update_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (update_valid) begin
              up_pc_q      <= update_pc[31:2];
              up_tgt_q     <= update_target;
              state        <= WRITE;
              update_ready <= 1'b0;
            end
          end
          WRITE: begin
            state        <= IDLE;
            update_ready <= 1'b1;
          end
          default: begin
            state        <= IDLE;
            update_ready <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_btb_array.sv
// Directed bench for btb_array: lookups push expectations into a queue that a
// negedge monitor pops and compares; handshake/flush/reset are checked inline.
module tb_btb_array;
  logic        clk = 1'b0;
  logic        rst, flush, lookup_valid, update_valid;
  logic [31:0] lookup_pc, update_pc, update_target;
  logic        lookup_hit, update_ready;
  logic [1:0]  lookup_way;
  logic [31:0] lookup_target;

  always #5 clk = ~clk;

  btb_array #(.b_sets(3), .way(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .lookup_hit(lookup_hit), .lookup_way(lookup_way), .lookup_target(lookup_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .update_ready(update_ready)
  );

  typedef struct {
    logic        hit;
    logic [1:0]  way;
    logic [31:0] tgt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic lk_seen = 1'b0;

  always @(posedge clk) lk_seen <= lookup_valid && !flush && !rst;

  always @(negedge clk) begin
    if (lk_seen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_lookup: got hit=%0d with no expectation queued", lookup_hit);
      end else begin
        e = exp_q.pop_front();
        if (lookup_hit !== e.hit || lookup_way !== e.way || lookup_target !== e.tgt) begin
          bad++;
          $display("FAIL %s: got hit=%0d way=%0d tgt=%h, want hit=%0d way=%0d tgt=%h",
                   e.name, lookup_hit, lookup_way, lookup_target, e.hit, e.way, e.tgt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input string name);
    check({name, "_ready_before"}, 32'(update_ready), 32'd1);
    update_valid = 1'b1; update_pc = pc; update_target = tgt;
    @(posedge clk); #1;
    update_valid = 1'b0;
    check({name, "_ready_write"}, 32'(update_ready), 32'd0);
    @(posedge clk); #1;
    check({name, "_ready_after"}, 32'(update_ready), 32'd1);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic h, input logic [1:0] w,
                        input logic [31:0] t, input string name);
    exp_q.push_back('{hit: h, way: w, tgt: t, name: name});
    lookup_valid = 1'b1; lookup_pc = pc;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
  endtask

  localparam logic [31:0] PA = 32'h0000_1000, PB = 32'h0000_2000, PC = 32'h0000_3000,
                          PD = 32'h0000_4000, PE = 32'h0000_5000, PF = 32'h0000_6000;
  localparam logic [31:0] PG = 32'h0001_0008, PH = 32'h0002_0008, PI = 32'h0003_0008,
                          PJ = 32'h0004_0008, PK = 32'h0005_0008;
  localparam logic [31:0] PX = 32'h0000_0010, PL = 32'h0000_7000, PM = 32'h0000_8000;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; lookup_valid = 1'b0; update_valid = 1'b0;
    lookup_pc = '0; update_pc = '0; update_target = '0;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", 32'(update_ready), 32'd1);
    check("reset_hit", 32'(lookup_hit), 32'd0);
    check("reset_target", lookup_target, 32'd0);
    lookup(PA, 1'b0, 2'd0, 32'h0, "cold_miss");

    // Set 0: first write lands in way 0, then fill ways 1-3.
    do_update(PA, 32'h0000_2000, "upd_a");
    lookup(PA, 1'b1, 2'd0, 32'h0000_2000, "hit_a");
    @(posedge clk); #1;
    check("idle_clears_hit", 32'(lookup_hit), 32'd0);
    do_update(PB, 32'h0000_B000, "upd_b");
    do_update(PC, 32'h0000_C000, "upd_c");
    do_update(PD, 32'h0000_D000, "upd_d");
    lookup(PD, 1'b1, 2'd3, 32'h0000_D000, "hit_d");

    // Re-update B: overwritten in place at way 1.
    do_update(PB, 32'h0000_3000, "reupd_b");
    lookup(PB, 1'b1, 2'd1, 32'h0000_3000, "hit_b_new");
    // Touch C then A: plru becomes 000, victim is way 3.
    lookup(PC, 1'b1, 2'd2, 32'h0000_C000, "hit_c");
    lookup(PA, 1'b1, 2'd0, 32'h0000_2000, "hit_a2");
    do_update(PE, 32'h0000_E000, "upd_e");
    lookup(PE, 1'b1, 2'd3, 32'h0000_E000, "hit_e_way3");
    lookup(PD, 1'b0, 2'd0, 32'h0, "d_evicted");
    // plru now 101: victim is way 1.
    do_update(PF, 32'h0000_F000, "upd_f");
    lookup(PF, 1'b1, 2'd1, 32'h0000_F000, "hit_f_way1");
    lookup(PB, 1'b0, 2'd0, 32'h0, "b_evicted");

    // Set 2: fill, then rewrite J with a lookup of J on the commit edge.
    do_update(PG, 32'h0000_00A0, "upd_g");
    do_update(PH, 32'h0000_00A1, "upd_h");
    do_update(PI, 32'h0000_00A2, "upd_i");
    do_update(PJ, 32'h0000_00A3, "upd_j");
    check("j2_ready_before", 32'(update_ready), 32'd1);
    update_valid = 1'b1; update_pc = PJ; update_target = 32'h0000_00B3;
    @(posedge clk); #1;
    update_valid = 1'b0;
    lookup(PJ, 1'b1, 2'd3, 32'h0000_00A3, "j_old_on_commit");
    check("j2_ready_after", 32'(update_ready), 32'd1);
    // plru 111 after both touches: victim is way 0.
    do_update(PK, 32'h0000_00A5, "upd_k");
    lookup(PK, 1'b1, 2'd0, 32'h0000_00A5, "hit_k_way0");
    lookup(PG, 1'b0, 2'd0, 32'h0, "g_evicted");
    lookup(PJ, 1'b1, 2'd3, 32'h0000_00B3, "hit_j_new");

    // Flush during WRITE, with a lookup of valid entry A on the same edge.
    check("x_ready_before", 32'(update_ready), 32'd1);
    update_valid = 1'b1; update_pc = PX; update_target = 32'h0000_1234;
    @(posedge clk); #1;
    update_valid = 1'b0;
    flush = 1'b1; lookup_valid = 1'b1; lookup_pc = PA;
    @(posedge clk); #1;
    flush = 1'b0; lookup_valid = 1'b0;
    check("flush_ready", 32'(update_ready), 32'd1);
    check("flush_hit", 32'(lookup_hit), 32'd0);
    check("flush_target", lookup_target, 32'd0);
    lookup(PX, 1'b0, 2'd0, 32'h0, "x_dropped");
    lookup(PA, 1'b0, 2'd0, 32'h0, "a_flushed");
    lookup(PJ, 1'b0, 2'd0, 32'h0, "j_flushed");

    // Async reset mid-cycle while an update is captured.
    do_update(PL, 32'h0000_7777, "upd_l");
    exp_q.push_back('{hit: 1'b1, way: 2'd0, tgt: 32'h0000_7777, name: "hit_l"});
    lookup_valid = 1'b1; lookup_pc = PL;
    update_valid = 1'b1; update_pc = PM; update_target = 32'h0000_8888;
    @(posedge clk); #1;
    lookup_valid = 1'b0; update_valid = 1'b0;
    check("m_ready_write", 32'(update_ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_hit", 32'(lookup_hit), 32'd0);
    check("rst_way", 32'(lookup_way), 32'd0);
    check("rst_target", lookup_target, 32'd0);
    check("rst_ready", 32'(update_ready), 32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    lookup(PM, 1'b0, 2'd0, 32'h0, "m_dropped");
    lookup(PL, 1'b0, 2'd0, 32'h0, "l_reset");

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
